// File: rtl/counter_monitor_pkg.sv
// counter_monitor_pkg: state encoding shared by the monitor and benches decoding its state output
package counter_monitor_pkg;
  localparam int ST_W = 2;
  typedef enum logic [ST_W-1:0] {
    ST_ARMED = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;
endpackage

// File: rtl/counter_monitor_if.sv
// counter_monitor_if: counter signals under check plus the monitor's report outputs
interface counter_monitor_if #(parameter int WIDTH = 3, parameter int ERR_W = 4);
  logic en;
  logic [WIDTH-1:0] count;
  logic mismatch;
  logic fault;
  logic wrap;
  logic [ERR_W-1:0] err_cnt;
  logic [WIDTH-1:0] exp_count;
  logic [1:0] state;
  modport master (output en, count, input mismatch, fault, wrap, err_cnt, exp_count, state);
  modport slave (input en, count, output mismatch, fault, wrap, err_cnt, exp_count, state);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous active-high reset
module sat_counter #(parameter int W = 4) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/counter_monitor.sv
// counter_monitor: passive reference-model checker for a gated up-counter
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int WIDTH         = 3,
  parameter int ERR_W         = 4,
  parameter bit STOP_ON_FAULT = 1'b0
) (
  input logic clk,
  input logic reset,
  counter_monitor_if.slave mon
);
  state_t st;
  state_t cur;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] nxt_exp;
  logic eq;
  logic err_inc;
  assign cur = (st == ST_TRACK || st == ST_FAULT) ? st : ST_ARMED;
  assign nxt_exp = exp_q + WIDTH'(mon.en);
  // An X/Z count never takes the equal branch, so it counts as a mismatch
  always_comb begin
    eq = 1'b0;
    if (mon.count == exp_q) eq = 1'b1;
  end
  assign err_inc = (cur == ST_TRACK) && !eq;
  always_ff @(posedge clk)
    if (reset) begin
      exp_q        <= '0;
      st           <= ST_ARMED;
      mon.mismatch <= 1'b0;
      mon.fault    <= 1'b0;
      mon.wrap     <= 1'b0;
    end else begin
      mon.wrap     <= (cur != ST_FAULT) && (&exp_q) && mon.en;
      mon.mismatch <= err_inc;
      if (cur == ST_ARMED) begin
        st    <= ST_TRACK;
        exp_q <= nxt_exp;
      end else if (cur == ST_TRACK) begin
        if (eq) exp_q <= nxt_exp;
        else begin
          mon.fault <= 1'b1;
          if (STOP_ON_FAULT) st <= ST_FAULT;
          else exp_q <= mon.count + WIDTH'(mon.en);
        end
      end
    end
  sat_counter #(.W(ERR_W)) u_err (
    .clk  (clk),
    .reset(reset),
    .inc  (err_inc),
    .q    (mon.err_cnt)
  );
  assign mon.exp_count = exp_q;
  assign mon.state     = st;
endmodule
